sync_down_counter: RTL and testbench

Synchronous loadable down-counter/timer. It is the counting-down counterpart of the team's synchronous up-counter. A value is loaded, then the block decrements on every enabled clock until it reaches zero, emitting a one-cycle terminal-count pulse. It supports one-shot and auto-reload (periodic) modes and serves as the timeout/period generator for control logic.

---
 rtl/sync_down_counter.sv | 75 +++++++
 tb/tb_sync_down_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and a
// registered one-cycle terminal-count pulse.
module sync_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             at_one;

  assign at_one = (cnt_q == WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (at_one) begin
        tc_d = 1'b1;
        // Auto-reload wraps 1 -> reload value without ever showing 0.
        if (auto_reload) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign q    = cnt_q;
  assign busy = (state_q == RUN);
  assign tc   = tc_q;
  assign zero = (cnt_q == '0);

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter (WIDTH=4).
module tb_sync_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [3:0] q;
  logic       busy;
  logic       tc;
  logic       zero;

  int unsigned total = 0;
  int unsigned bad   = 0;

  sync_down_counter #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .tc          (tc),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic eb,
                         input logic et, input logic ez);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".tc"},   32'(tc),   32'(et));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
  endtask

  initial begin
    logic [3:0] ar_seq [9];
    logic [3:0] en_q   [7];
    logic       en_seq [7];

    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    repeat (3) tick();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk_all("idle_en1", 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("idle_en2", 4'd0, 1'b0, 1'b0, 1'b1);

    // One-shot from 5
    load = 1'b1; load_val = 4'd5; auto_reload = 1'b0; en = 1'b1;
    tick();
    chk_all("os_load", 4'd5, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk_all($sformatf("os_q%0d", i), 4'(i), (i != 0), (i == 0), (i == 0));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("os_hold%0d", i), 4'd0, 1'b0, 1'b0, 1'b1);
    end

    // Auto-reload period 3
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
    tick();
    chk_all("ar_load", 4'd3, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    ar_seq = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_all($sformatf("ar_%0d", i), ar_seq[i], 1'b1, (ar_seq[i] == 4'd3), 1'b0);
    end

    // Enable gating from 15; en on the load edge is ignored
    load = 1'b1; load_val = 4'd15; auto_reload = 1'b0; en = 1'b1;
    tick();
    chk_all("eg_load", 4'd15, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    en_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    en_q   = '{4'd14, 4'd14, 4'd14, 4'd13, 4'd12, 4'd12, 4'd11};
    for (int i = 0; i < 7; i++) begin
      en = en_seq[i];
      tick();
      chk_all($sformatf("eg_%0d", i), en_q[i], 1'b1, 1'b0, 1'b0);
    end

    // Zero load: straight to IDLE, no tc
    load = 1'b1; load_val = 4'd0; en = 1'b1;
    tick();
    chk_all("load0", 4'd0, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    tick();
    chk_all("load0_hold", 4'd0, 1'b0, 1'b0, 1'b1);

    // Load during run at q=2
    load = 1'b1; load_val = 4'd4; en = 1'b1; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk_all("lr_q2", 4'd2, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd9;
    tick();
    chk_all("lr_load9", 4'd9, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    repeat (8) tick();
    chk_all("lr_q1", 4'd1, 1'b1, 1'b0, 1'b0);
    // Load beats the terminal edge
    load = 1'b1; load_val = 4'd6;
    tick();
    chk_all("lr_term_load", 4'd6, 1'b1, 1'b0, 1'b0);
    load = 1'b0;

    // Auto-reload with reload value 1: tc every enabled cycle
    load = 1'b1; load_val = 4'd1; auto_reload = 1'b1; en = 1'b1;
    tick();
    chk_all("r1_load", 4'd1, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    chk_all("r1_a", 4'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("r1_b", 4'd1, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    chk_all("r1_hold", 4'd1, 1'b1, 1'b0, 1'b0);

    // Async reset mid-run at q=4
    load = 1'b1; load_val = 4'd7; auto_reload = 1'b0; en = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    chk_all("ar_pre", 4'd4, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("post_rst", 4'd0, 1'b0, 1'b0, 1'b1);

    // Async reset clears a pending tc
    load = 1'b1; load_val = 4'd1; auto_reload = 1'b0; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk_all("tc_pre", 4'd0, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("tc_rst", 4'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
